// File: rtl/seq_event_logger_pkg.sv
// seq_event_logger_pkg: event record layout and drop-counter width shared by the logger and its bench.
package seq_event_logger_pkg;
    localparam int NIB_W   = 4;
    localparam int NEW_LSB = 0;
    localparam int OLD_LSB = NEW_LSB + NIB_W;
    localparam int TS_LSB  = OLD_LSB + NIB_W;
    localparam int DROP_W  = 8;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction
endpackage

// File: rtl/seq_event_logger_fifo.sv
// evt_fifo: show-ahead FIFO with a registered head that holds its last value when the FIFO drains.
module evt_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign level = cnt_q;
    assign dout  = dout_q;

    // The head slot is being written this edge when the new entry lands at the next read pointer.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rd_d    = rd_q + AW'(do_pop);
        wr_d    = wr_q + AW'(do_push);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        dout_d  = (cnt_d == '0) ? dout_q : ((do_push && wr_q == rd_d) ? din : mem_q[rd_d]);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end
endmodule

// File: rtl/seq_event_logger.sv
// seq_event_logger: timestamps changes of the {w,x,y,z} nibble and queues {ts, old, new} records,
// counting events dropped while the queue is full.
module seq_event_logger
    import seq_event_logger_pkg::*;
#(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w,
    input  logic                     x,
    input  logic                     y,
    input  logic                     z,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [TS_W+7:0]          ev_data,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int REC_W = TS_W + 2 * NIB_W;

    logic [TS_W-1:0]   ts_q, ts_d, cur_ts_q, cur_ts_d;
    logic [NIB_W-1:0]  cur_q, cur_d, prev_q, prev_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [REC_W-1:0]  rec;
    logic              push, pop, full, empty, drop;

    assign ev_valid = !empty;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

    // A drop coinciding with a clear survives the clear and restarts the count at one.
    always_comb begin
        ts_d       = ts_q + TS_W'(1);
        cur_d      = {w, x, y, z};
        prev_d     = cur_q;
        cur_ts_d   = ts_q;
        push       = cur_q != prev_q;
        pop        = ev_valid && ev_ready;
        drop       = push && full && !pop;
        ovf_d      = drop || (ovf_q && !ovf_clr);
        drop_cnt_d = ovf_clr ? DROP_W'(drop) : (drop ? sat_inc(drop_cnt_q) : drop_cnt_q);
        rec                   = '0;
        rec[TS_LSB +: TS_W]   = cur_ts_q;
        rec[OLD_LSB +: NIB_W] = prev_q;
        rec[NEW_LSB +: NIB_W] = cur_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            cur_ts_q   <= '0;
            cur_q      <= '0;
            prev_q     <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            cur_ts_q   <= cur_ts_d;
            cur_q      <= cur_d;
            prev_q     <= prev_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    evt_fifo #(
        .WIDTH(REC_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .din  (rec),
        .dout (ev_data),
        .full (full),
        .empty(empty),
        .level(level)
    );
endmodule

// File: tb/tb_seq_event_logger.sv
// tb_seq_event_logger: directed scoreboard bench for seq_event_logger, with a 4-bit timestamp copy for wrap checks.
module tb_seq_event_logger;
    logic clk = 1'b0, rst_n = 1'b1, w = 1'b0, x = 1'b0, y = 1'b0, z = 1'b0;
    logic ev_ready = 1'b0, ovf_clr = 1'b0;
    logic ev_valid, ovf, ev_valid4, ovf4;
    logic [23:0] ev_data;
    logic [11:0] ev_data4;
    logic [7:0]  drop_cnt, drop4;
    logic [3:0]  level, level4;
    logic [15:0] mts;
    logic [3:0]  cur_m = 4'b0000;
    logic [23:0] last_rec;
    logic [23:0] exp_q[$];
    logic [11:0] exp4_q[$];
    int n_assert = 0, n_fail = 0;

    seq_event_logger #(.TS_W(16), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .w(w), .x(x), .y(y), .z(z),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .ovf(ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt), .level(level)
    );

    seq_event_logger #(.TS_W(4), .DEPTH(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .w(w), .x(x), .y(y), .z(z),
        .ev_valid(ev_valid4), .ev_ready(1'b1), .ev_data(ev_data4),
        .ovf(ovf4), .ovf_clr(1'b0), .drop_cnt(drop4), .level(level4)
    );

    always #5 clk = ~clk;

    // Reference timestamp: cycles since reset release.
    always @(posedge clk or negedge rst_n) mts <= !rst_n ? 16'd0 : mts + 16'd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The next edge loads cur, so the record's ts is the current reference count.
    task automatic drive(input logic [3:0] nib, input bit keep);
        if (nib != cur_m) begin
            if (keep) exp_q.push_back({mts, cur_m, nib});
            exp4_q.push_back({mts[3:0], cur_m, nib});
        end
        cur_m = nib;
        {w, x, y, z} = nib;
    endtask

    task automatic wait_ts(input logic [15:0] v, input logic [15:0] m);
        int n = 0;
        while ((mts & m) != v && n < 100) begin
            tick();
            n++;
        end
        chk("wait_ts", 32'(n < 100), 1);
    endtask

    always @(negedge clk) begin
        if (ev_valid && ev_ready) begin
            chk("pop_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("ev_data", 32'(ev_data), 32'(exp_q.pop_front()));
        end
        if (ev_valid4) begin
            chk("pop4_expected", 32'(exp4_q.size() != 0), 1);
            if (exp4_q.size() != 0) chk("ev_data4", 32'(ev_data4), 32'(exp4_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_data", 32'(ev_data), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        ev_ready = 1'b1;
        drive(4'b0000, 1);
        // Single change at ts 10, then the w/x/y/z sequence.
        wait_ts(16'd10, 16'hffff);
        drive(4'b0100, 1);
        tick();
        chk("lat1_valid", 32'(ev_valid), 0);
        tick();
        chk("lat2_valid", 32'(ev_valid), 1);
        chk("lat2_data", 32'(ev_data), 32'({16'd10, 4'b0000, 4'b0100}));
        chk("lat2_level", 32'(level), 1);
        wait_ts(16'd15, 16'hffff);
        drive(4'b0100, 1);
        wait_ts(16'd35, 16'hffff);
        drive(4'b0101, 1);
        repeat (3) tick();
        chk("seq_drained", exp_q.size(), 0);
        chk("seq_level", 32'(level), 0);
        // Overflow: 10 toggles into 8 slots with the consumer stalled.
        ev_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(cur_m ^ 4'b0001, i < 8);
            tick();
        end
        repeat (2) tick();
        chk("ovf_level", 32'(level), 8);
        chk("ovf_flag", 32'(ovf), 1);
        chk("ovf_drop", 32'(drop_cnt), 2);
        chk("ovf_valid", 32'(ev_valid), 1);
        tick();
        chk("stall_head", 32'(ev_data), 32'(exp_q[0]));
        for (int i = 0; i < 255; i++) begin
            drive(cur_m ^ 4'b0010, 0);
            tick();
        end
        repeat (2) tick();
        chk("drop_sat", 32'(drop_cnt), 255);
        chk("sat_level", 32'(level), 8);
        // Clear on the same edge as a drop.
        drive(cur_m ^ 4'b0001, 0);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_drop_ovf", 32'(ovf), 1);
        chk("clr_drop_cnt", 32'(drop_cnt), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 0);
        chk("clr_cnt", 32'(drop_cnt), 0);
        last_rec = exp_q[$];
        ev_ready = 1'b1;
        repeat (10) tick();
        chk("drain_sb", exp_q.size(), 0);
        chk("drain_level", 32'(level), 0);
        chk("drain_valid", 32'(ev_valid), 0);
        chk("hold_empty", 32'(ev_data), 32'(last_rec));
        // Push and pop on the same edge while full.
        ev_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(cur_m ^ 4'b1000, 1);
            tick();
        end
        repeat (2) tick();
        chk("full_level", 32'(level), 8);
        drive(cur_m ^ 4'b1000, 1);
        tick();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        chk("full_pp_level", 32'(level), 8);
        chk("full_pp_drop", 32'(drop_cnt), 0);
        chk("full_pp_ovf", 32'(ovf), 0);
        ev_ready = 1'b1;
        repeat (12) tick();
        chk("drain2_sb", exp_q.size(), 0);
        chk("drain2_level", 32'(level), 0);
        // Push and pop on the same edge at level 1.
        drive(cur_m ^ 4'b0100, 1);
        tick();
        drive(cur_m ^ 4'b0100, 1);
        tick();
        chk("l1_valid_a", 32'(ev_valid), 1);
        chk("l1_level_a", 32'(level), 1);
        tick();
        chk("l1_valid_b", 32'(ev_valid), 1);
        chk("l1_level_b", 32'(level), 1);
        tick();
        chk("l1_valid_c", 32'(ev_valid), 0);
        // Timestamp wrap on the 4-bit build.
        wait_ts(16'd15, 16'h000f);
        drive(cur_m ^ 4'b0001, 1);
        wait_ts(16'd1, 16'h000f);
        drive(cur_m ^ 4'b0001, 1);
        repeat (3) tick();
        chk("wrap_sb4", exp4_q.size(), 0);
        chk("wrap_sb", exp_q.size(), 0);
        // Reset with three entries buffered.
        ev_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(cur_m ^ 4'b0010, 1);
            tick();
        end
        repeat (2) tick();
        chk("pre_rst_level", 32'(level), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ev_valid), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_data", 32'(ev_data), 0);
        chk("arst_valid4", 32'(ev_valid4), 0);
        exp_q.delete();
        exp4_q.delete();
        cur_m = 4'b0000;
        tick();
        rst_n = 1'b1;
        ev_ready = 1'b1;
        drive(4'b1001, 1);
        tick();
        tick();
        chk("post_rst_valid", 32'(ev_valid), 1);
        chk("post_rst_data", 32'(ev_data), 32'({16'd0, 4'b0000, 4'b1001}));
        repeat (3) tick();
        chk("post_rst_sb", exp_q.size(), 0);
        chk("post_rst_level", 32'(level), 0);
        chk("end_level4", 32'(level4), 0);
        chk("end_ovf4", 32'(ovf4), 0);
        chk("end_drop4", 32'(drop4), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
